// File: rtl/noc16_block_cipher_engine.sv
// rtl/noc16_block_cipher_engine.sv - NOC16 iterative block-cipher peripheral with key store and input FIFO
module noc16_block_cipher_engine #(
    parameter int          NUM_ROUNDS = 10,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [7:0]  CMD_OUT    = 8'hFF,
    parameter logic [23:0] SERIAL     = 24'd9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] Ksubs3_Noc16_RxData_lo,
    input  logic [7:0]  Ksubs3_Noc16_RxData_cmd,
    input  logic        Ksubs3_Noc16_RxData_valid,
    output logic        Ksubs3_Noc16_RxData_rdy,
    output logic [63:0] Ksubs3_Noc16_TxData_lo,
    output logic [7:0]  Ksubs3_Noc16_TxData_cmd,
    output logic        Ksubs3_Noc16_TxData_valid,
    input  logic        Ksubs3_Noc16_TxData_rdy,
    output logic [23:0] designSerialNumber,
    output logic        busy,
    output logic [15:0] blocks_done
);

    localparam int KEY_BEATS = 2 * (NUM_ROUNDS + 1);
    localparam int KIW       = $clog2(KEY_BEATS + 1);
    localparam int KSW       = $clog2(NUM_ROUNDS + 1);
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROUND  = 2'd1,
        S_OUT_LO = 2'd2,
        S_OUT_HI = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [127:0]   r_rk   [0:NUM_ROUNDS];
    logic [127:0]   r_fifo [0:FIFO_DEPTH-1];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [63:0]    r_stage;
    logic           r_stage_odd;

    logic [KIW-1:0] r_key_idx;
    logic           r_keys_ready;
    logic [1:0]     r_iv_idx;
    logic [63:0]    r_iv_lo;
    logic           r_mode;
    logic [127:0]   r_chain;

    logic [127:0]   r_block;
    logic [127:0]   r_ct;
    logic [KSW-1:0] r_round;

    logic [63:0]    r_tx_lo;
    logic [7:0]     r_tx_cmd;
    logic           r_tx_valid;
    logic [23:0]    r_serial;
    logic [15:0]    r_blocks_done;

    logic           w_rx_rdy;
    logic           w_rx_fire;
    logic           w_key_beat;
    logic           w_iv_beat;
    logic           w_data_beat;
    logic           w_ctl_beat;
    logic           w_key_wr;
    logic [KSW-1:0] w_key_slot;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_last_round;
    logic [127:0]   w_round_out;
    logic [127:0]   w_ct;

    // Round transform hook; a future generation drops SubBytes/ShiftRows/MixCols in here.
    function automatic logic [127:0] f_round(input logic [127:0] x);
        return x;
    endfunction

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    // Config beats only land while idle so the key store and chain never change under a block.
    always_comb begin
        w_rx_rdy = 1'b1;
        case (Ksubs3_Noc16_RxData_cmd)
            8'd0, 8'd1, 8'd3: w_rx_rdy = (r_state == S_IDLE);
            8'd2:             w_rx_rdy = !w_full;
            default:          w_rx_rdy = 1'b1;
        endcase
    end

    assign w_rx_fire   = Ksubs3_Noc16_RxData_valid && w_rx_rdy;
    assign w_key_beat  = w_rx_fire && (Ksubs3_Noc16_RxData_cmd == 8'd0);
    assign w_iv_beat   = w_rx_fire && (Ksubs3_Noc16_RxData_cmd == 8'd1);
    assign w_data_beat = w_rx_fire && (Ksubs3_Noc16_RxData_cmd == 8'd2);
    assign w_ctl_beat  = w_rx_fire && (Ksubs3_Noc16_RxData_cmd == 8'd3);
    assign w_key_wr    = w_key_beat && (r_key_idx < KIW'(KEY_BEATS));
    assign w_key_slot  = KSW'(r_key_idx >> 1);
    assign w_push      = w_data_beat && r_stage_odd;

    assign w_round_out  = f_round(r_block ^ r_rk[r_round]);
    assign w_ct         = w_round_out ^ r_rk[NUM_ROUNDS];
    assign w_last_round = (r_round == KSW'(NUM_ROUNDS - 1));

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_keys_ready && !w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_ROUND;
                end
            end
            S_ROUND: begin
                if (w_last_round) begin
                    w_next_state = S_OUT_LO;
                end
            end
            S_OUT_LO: begin
                if (Ksubs3_Noc16_TxData_rdy) begin
                    w_next_state = S_OUT_HI;
                end
            end
            S_OUT_HI: begin
                if (Ksubs3_Noc16_TxData_rdy) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Storage arrays carry no reset; the indices and keys_ready gate their use.
    always_ff @(posedge clk) begin
        if (w_key_wr) begin
            if (r_key_idx[0]) begin
                r_rk[w_key_slot][127:64] <= Ksubs3_Noc16_RxData_lo;
            end else begin
                r_rk[w_key_slot][63:0] <= Ksubs3_Noc16_RxData_lo;
            end
        end
        if (w_data_beat && !r_stage_odd) begin
            r_stage <= Ksubs3_Noc16_RxData_lo;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {Ksubs3_Noc16_RxData_lo, r_stage};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_stage_odd   <= 1'b0;
            r_key_idx     <= '0;
            r_keys_ready  <= 1'b0;
            r_iv_idx      <= '0;
            r_iv_lo       <= '0;
            r_mode        <= 1'b0;
            r_chain       <= '0;
            r_block       <= '0;
            r_ct          <= '0;
            r_round       <= '0;
            r_tx_lo       <= '0;
            r_tx_cmd      <= '0;
            r_tx_valid    <= 1'b0;
            r_serial      <= '0;
            r_blocks_done <= '0;
        end else begin
            r_serial <= SERIAL;

            if (w_data_beat) begin
                r_stage_odd <= !r_stage_odd;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_key_wr) begin
                r_key_idx <= r_key_idx + 1'b1;
                if (r_key_idx == KIW'(KEY_BEATS - 1)) begin
                    r_keys_ready <= 1'b1;
                end
            end

            if (w_ctl_beat) begin
                r_mode <= Ksubs3_Noc16_RxData_lo[0];
                if (Ksubs3_Noc16_RxData_lo[1]) begin
                    r_key_idx    <= '0;
                    r_iv_idx     <= '0;
                    r_keys_ready <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_block <= r_fifo[r_rd_ptr] ^ (r_mode ? r_chain : 128'd0);
                        r_round <= '0;
                    end
                end
                S_ROUND: begin
                    r_block <= w_round_out;
                    r_round <= r_round + 1'b1;
                    if (w_last_round) begin
                        r_ct       <= w_ct;
                        r_tx_lo    <= w_ct[63:0];
                        r_tx_cmd   <= CMD_OUT;
                        r_tx_valid <= 1'b1;
                    end
                end
                S_OUT_LO: begin
                    if (Ksubs3_Noc16_TxData_rdy) begin
                        r_tx_lo <= r_ct[127:64];
                    end
                end
                S_OUT_HI: begin
                    if (Ksubs3_Noc16_TxData_rdy) begin
                        r_tx_valid    <= 1'b0;
                        r_chain       <= r_ct;
                        r_blocks_done <= r_blocks_done + 16'd1;
                    end
                end
                default: ;
            endcase

            // IV beats are only accepted in IDLE, so they never race the OUT_HI chain update.
            if (w_iv_beat) begin
                if (r_iv_idx == 2'd0) begin
                    r_iv_lo  <= Ksubs3_Noc16_RxData_lo;
                    r_iv_idx <= 2'd1;
                end else if (r_iv_idx == 2'd1) begin
                    r_chain  <= {Ksubs3_Noc16_RxData_lo, r_iv_lo};
                    r_iv_idx <= 2'd2;
                end
            end
        end
    end

    assign Ksubs3_Noc16_RxData_rdy   = w_rx_rdy;
    assign Ksubs3_Noc16_TxData_lo    = r_tx_lo;
    assign Ksubs3_Noc16_TxData_cmd   = r_tx_cmd;
    assign Ksubs3_Noc16_TxData_valid = r_tx_valid;
    assign designSerialNumber        = r_serial;
    assign busy                      = (r_state != S_IDLE);
    assign blocks_done               = r_blocks_done;

endmodule

// File: tb/tb_noc16_block_cipher_engine.sv
// tb/tb_noc16_block_cipher_engine.sv - self-checking bench for noc16_block_cipher_engine
module tb_noc16_block_cipher_engine;

    localparam int NR = 2;
    localparam int FD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] rx_lo = '0;
    logic [7:0]  rx_cmd = '0;
    logic        rx_valid = 1'b0;
    logic        rx_rdy;
    logic [63:0] tx_lo;
    logic [7:0]  tx_cmd;
    logic        tx_valid;
    logic        tx_rdy;
    logic [23:0] serial;
    logic        busy;
    logic [15:0] blocks_done;

    always #5 clk = ~clk;

    noc16_block_cipher_engine #(
        .NUM_ROUNDS(NR),
        .FIFO_DEPTH(FD),
        .CMD_OUT(8'hFF),
        .SERIAL(24'd9)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Ksubs3_Noc16_RxData_lo(rx_lo),
        .Ksubs3_Noc16_RxData_cmd(rx_cmd),
        .Ksubs3_Noc16_RxData_valid(rx_valid),
        .Ksubs3_Noc16_RxData_rdy(rx_rdy),
        .Ksubs3_Noc16_TxData_lo(tx_lo),
        .Ksubs3_Noc16_TxData_cmd(tx_cmd),
        .Ksubs3_Noc16_TxData_valid(tx_valid),
        .Ksubs3_Noc16_TxData_rdy(tx_rdy),
        .designSerialNumber(serial),
        .busy(busy),
        .blocks_done(blocks_done)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] m_k [0:NR];
    logic         m_cbc = 1'b0;
    logic [127:0] m_chain = '0;
    logic [127:0] m_pt [$];
    int           m_done = 0;
    logic [63:0]  tx_q [$];
    logic [63:0]  last_lo;
    logic [63:0]  last_hi;
    int           rdy_mode = 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_vec++;
        n_err++;
        $display("FAIL %s timeout observed=none expected=event", tag);
    endtask

    // Reference: with an identity round, ciphertext is the whitened block XORed with every key.
    function automatic logic [127:0] model_ct(input logic [127:0] pt);
        logic [127:0] x;
        x = pt ^ (m_cbc ? m_chain : 128'd0);
        for (int r = 0; r <= NR; r++) x = x ^ m_k[r];
        return x;
    endfunction

    initial begin
        tx_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_rdy = 1'b0;
                1:       tx_rdy = 1'b1;
                default: tx_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic        p_stall = 1'b0;
    logic [63:0] p_lo = '0;
    always @(negedge clk) begin
        if (reset) begin
            p_stall <= 1'b0;
        end else begin
            if (p_stall) begin
                chk("hold_valid", tx_valid, 1'b1);
                chk("hold_lo", tx_lo, p_lo);
            end
            if (tx_valid && tx_rdy) begin
                tx_q.push_back(tx_lo);
                chk("tx_cmd", tx_cmd, 8'hFF);
            end
            p_stall <= tx_valid && !tx_rdy;
            p_lo    <= tx_lo;
        end
    end

    task automatic send(input logic [7:0] c, input logic [63:0] d);
        int n;
        rx_valid = 1'b1;
        rx_cmd   = c;
        rx_lo    = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (rx_rdy) break;
            n++;
            if (n > 2000) begin
                timeout_fail("rx_send");
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic probe_rdy(input string tag, input logic [7:0] c, input logic exp);
        @(negedge clk);
        rx_cmd   = c;
        rx_lo    = 64'($urandom);
        rx_valid = 1'b1;
        #1;
        chk(tag, rx_rdy, exp);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_keys();
        for (int k = 0; k <= NR; k++) begin
            send(8'd0, m_k[k][63:0]);
            send(8'd0, m_k[k][127:64]);
        end
    endtask

    task automatic rand_keys();
        for (int k = 0; k <= NR; k++) m_k[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic push_iv(input logic [127:0] iv);
        send(8'd1, iv[63:0]);
        send(8'd1, iv[127:64]);
        m_chain = iv;
    endtask

    task automatic set_mode(input logic cbc, input logic clr);
        send(8'd3, {62'd0, clr, cbc});
        m_cbc = cbc;
    endtask

    task automatic push_block(input logic [127:0] b);
        send(8'd2, b[63:0]);
        send(8'd2, b[127:64]);
        m_pt.push_back(b);
    endtask

    task automatic drain(input int nb);
        int n;
        logic [127:0] e;
        n = 0;
        while (tx_q.size() < 2 * nb && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx_q.size() < 2 * nb) begin
            timeout_fail("drain");
            tx_q.delete();
            m_pt.delete();
        end else begin
            for (int i = 0; i < nb; i++) begin
                e = model_ct(m_pt.pop_front());
                m_chain = e;
                m_done++;
                last_lo = tx_q.pop_front();
                last_hi = tx_q.pop_front();
                chk("ct_lo", last_lo, e[63:0]);
                chk("ct_hi", last_hi, e[127:64]);
            end
        end
        @(posedge clk);
        #1;
        chk("blocks_done", blocks_done, 16'(m_done));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cbc = 1'b0;
        m_chain = '0;
        m_done = 0;
        m_pt.delete();
        tx_q.delete();
        @(negedge clk);
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_lo", tx_lo, 64'd0);
        chk("rst_cmd", tx_cmd, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", blocks_done, 16'd0);
        chk("rst_serial", serial, 24'd0);
        @(negedge clk);
        chk("serial", serial, 24'd9);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) timeout_fail(tag);
    endtask

    initial begin
        int nb;
        logic cbc;

        repeat (2) @(posedge clk);
        do_reset();

        // T1 ECB directed
        m_k[0] = {64'd0, 64'd1};
        m_k[1] = {64'd0, 64'd2};
        m_k[2] = {64'h10, 64'd4};
        push_keys();
        push_block({64'd1, 64'hF0});
        drain(1);
        chk("t1_lo", last_lo, 64'hF7);
        chk("t1_hi", last_hi, 64'h11);

        // T2 CBC directed
        set_mode(1'b1, 1'b0);
        push_iv({64'd0, 64'h100});
        push_block('0);
        push_block('0);
        drain(1);
        chk("t2_ct1_lo", last_lo, 64'h107);
        chk("t2_ct1_hi", last_hi, 64'h10);
        drain(1);
        chk("t2_ct2_lo", last_lo, 64'h100);
        chk("t2_ct2_hi", last_hi, 64'h0);

        // Randomized ECB/CBC runs with random Tx backpressure
        for (int it = 0; it < 4; it++) begin
            cbc = 1'($urandom_range(0, 1));
            rdy_mode = 1;
            set_mode(cbc, 1'b1);
            rand_keys();
            push_keys();
            if (cbc) push_iv({$urandom, $urandom, $urandom, $urandom});
            rdy_mode = 2;
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) push_block({$urandom, $urandom, $urandom, $urandom});
            drain(nb);
        end

        // T3 backpressure and full FIFO
        rdy_mode = 0;
        for (int b = 0; b < 3; b++) push_block({$urandom, $urandom, $urandom, $urandom});
        wait_valid("t3_valid");
        probe_rdy("t3_rdy_full", 8'd2, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_valid_held", tx_valid, 1'b1);
        chk("t3_no_beats", tx_q.size(), 0);
        rdy_mode = 1;
        drain(3);

        // T4 data before keys
        set_mode(1'b0, 1'b1);
        push_block({$urandom, $urandom, $urandom, $urandom});
        push_block({$urandom, $urandom, $urandom, $urandom});
        repeat (30) @(posedge clk);
        #1;
        chk("t4_no_tx", tx_q.size(), 0);
        chk("t4_idle", busy, 1'b0);
        rand_keys();
        rdy_mode = 2;
        push_keys();
        drain(2);

        // T5 config commands while busy
        rdy_mode = 0;
        push_block({$urandom, $urandom, $urandom, $urandom});
        wait_valid("t5_valid");
        probe_rdy("t5_rdy_key", 8'd0, 1'b0);
        probe_rdy("t5_rdy_iv", 8'd1, 1'b0);
        probe_rdy("t5_rdy_ctl", 8'd3, 1'b0);
        probe_rdy("t5_rdy_drop", 8'd7, 1'b1);
        rdy_mode = 1;
        drain(1);
        push_block({$urandom, $urandom, $urandom, $urandom});
        drain(1);

        // T6 reset during ROUND
        set_mode(1'b0, 1'b1);
        push_block({$urandom, $urandom, $urandom, $urandom});
        push_block({$urandom, $urandom, $urandom, $urandom});
        rand_keys();
        push_keys();
        begin
            int n;
            n = 0;
            while (!busy && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!busy) timeout_fail("t6_busy");
        end
        #1;
        do_reset();
        push_block({$urandom, $urandom, $urandom, $urandom});
        repeat (20) @(posedge clk);
        #1;
        chk("t6_no_tx", tx_q.size(), 0);
        chk("t6_idle", busy, 1'b0);
        rand_keys();
        push_keys();
        drain(1);
        repeat (20) @(posedge clk);
        #1;
        chk("t6_fifo_empty", tx_q.size(), 0);
        chk("t6_done", blocks_done, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
